// File: rtl/lfsr_prng_stream.sv
// ============================================================================
//  Module      : lfsr_prng_stream
//  Description : Parametrised Fibonacci XNOR LFSR pseudo-random word source
//                with runtime seeding, lock-up protection, a valid/ready
//                output stream, period-completion pulse and step counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_Clk        in   1          system clock, rising edge
//    i_Rst_n      in   1          synchronous active-low reset
//    i_Enable     in   1          permits the LFSR to advance
//    i_Seed_DV    in   1          load i_Seed_Data this cycle
//    i_Seed_Data  in   NUM_BITS   seed value
//    o_Data       out  OUT_WIDTH  current pseudo-random word
//    o_Valid      out  1          o_Data holds an unconsumed word
//    i_Ready      in   1          consumer accepts o_Data on o_Valid&&i_Ready
//    o_Done       out  1          pulse: state returned to the seed value
//    o_Seed_Err   out  1          pulse: supplied seed was the lock-up value
//    o_Step_Cnt   out  NUM_BITS   advances since last seed/reset/period wrap
// ============================================================================
`default_nettype none

module lfsr_prng_stream #(
  parameter int                  NUM_BITS  = 8,
  parameter logic [NUM_BITS-1:0] TAPS      = 'hB8,
  parameter int                  OUT_WIDTH = 8
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic                 i_Enable,
  input  logic                 i_Seed_DV,
  input  logic [NUM_BITS-1:0]  i_Seed_Data,
  output logic [OUT_WIDTH-1:0] o_Data,
  output logic                 o_Valid,
  input  logic                 i_Ready,
  output logic                 o_Done,
  output logic                 o_Seed_Err,
  output logic [NUM_BITS-1:0]  o_Step_Cnt
);

  logic [NUM_BITS-1:0]  state;
  logic [NUM_BITS-1:0]  ref_seed;
  logic [OUT_WIDTH-1:0] data_q;
  logic                 valid_q;
  logic                 done_q;
  logic                 seed_err_q;
  logic [NUM_BITS-1:0]  step_cnt;

  logic                 feedback;
  logic                 lockup;
  logic                 seed_lockup;
  logic [NUM_BITS-1:0]  next_state;
  logic                 adv;
  logic                 wrap;

  // XNOR feedback makes all-ones the single stuck state; all-zeros is legal.
  assign feedback    = ~^(state & TAPS);
  assign lockup      = &state;
  assign seed_lockup = &i_Seed_Data;

  // A stuck all-ones state (only reachable with a bad tap mask) is escaped
  // by stepping to zero instead of the computed successor.
  assign next_state  = lockup ? '0 : {state[NUM_BITS-2:0], feedback};

  // A pending word blocks advancing unless it is being consumed this cycle,
  // which gives one word per cycle while the consumer stays ready.
  assign adv  = i_Enable && !i_Seed_DV && (!valid_q || i_Ready);
  assign wrap = (next_state == ref_seed);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state      <= '0;
      ref_seed   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
      step_cnt   <= '0;
    end else begin
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
      if (i_Seed_DV) begin
        // Seeding discards any pending word, even one handshaken this cycle.
        if (seed_lockup) begin
          state      <= '0;
          ref_seed   <= '0;
          seed_err_q <= 1'b1;
        end else begin
          state    <= i_Seed_Data;
          ref_seed <= i_Seed_Data;
        end
        valid_q  <= 1'b0;
        step_cnt <= '0;
      end else if (adv) begin
        state   <= next_state;
        data_q  <= next_state[OUT_WIDTH-1:0];
        valid_q <= 1'b1;
        if (wrap) begin
          done_q   <= 1'b1;
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + NUM_BITS'(1);
        end
      end else if (valid_q && i_Ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_Data     = data_q;
  assign o_Valid    = valid_q;
  assign o_Done     = done_q;
  assign o_Seed_Err = seed_err_q;
  assign o_Step_Cnt = step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_prng_stream.sv
// ============================================================================
//  Module      : tb_lfsr_prng_stream
//  Description : Self-checking bench for lfsr_prng_stream (default params).
//                Directed scenarios followed by randomized stimulus, all
//                checked against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_prng_stream;

  localparam int         NB   = 8;
  localparam int         OW   = 8;
  localparam logic [7:0] TAPS = 8'hB8;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          seed_dv;
  logic [NB-1:0] seed_data;
  logic [OW-1:0] data;
  logic          valid;
  logic          ready;
  logic          done;
  logic          seed_err;
  logic [NB-1:0] step_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  logic [NB-1:0] m_state, m_ref, m_data, m_step;
  logic          m_valid, m_done, m_err;

  lfsr_prng_stream #(.NUM_BITS(NB), .TAPS(TAPS), .OUT_WIDTH(OW)) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Enable    (enable),
    .i_Seed_DV   (seed_dv),
    .i_Seed_Data (seed_data),
    .o_Data      (data),
    .o_Valid     (valid),
    .i_Ready     (ready),
    .o_Done      (done),
    .o_Seed_Err  (seed_err),
    .o_Step_Cnt  (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Successor by rule: even parity over tapped bits gives feedback 1,
  // and the all-ones state escapes to zero.
  function automatic logic [NB-1:0] succ(input logic [NB-1:0] s);
    int ones;
    if (s == '1) return '0;
    ones = $countones(s & TAPS);
    return {s[NB-2:0], (ones % 2 == 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic model_edge();
    logic [NB-1:0] n;
    if (!rst_n) begin
      m_state = '0; m_ref = '0; m_data = '0; m_step = '0;
      m_valid = 0;  m_done = 0; m_err = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (seed_dv) begin
        if (seed_data == '1) begin
          m_state = '0; m_ref = '0; m_err = 1;
        end else begin
          m_state = seed_data; m_ref = seed_data;
        end
        m_valid = 0;
        m_step  = '0;
      end else if (enable && (!m_valid || ready)) begin
        n       = succ(m_state);
        m_state = n;
        m_data  = n;
        m_valid = 1;
        if (n == m_ref) begin
          m_done = 1;
          m_step = '0;
        end else begin
          m_step = m_step + 1'b1;
        end
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  endtask

  // One clock: update model on the edge, compare every output 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("data",     32'(data),     32'(m_data));
    check("valid",    32'(valid),    32'(m_valid));
    check("done",     32'(done),     32'(m_done));
    check("seed_err", 32'(seed_err), 32'(m_err));
    check("step_cnt", 32'(step_cnt), 32'(m_step));
  endtask

  initial begin : stim
    logic [7:0] exp_seq [5];
    logic [7:0] held;
    logic [7:0] prev_step;
    int         done_cnt;

    exp_seq[0] = 8'h01; exp_seq[1] = 8'h03; exp_seq[2] = 8'h07;
    exp_seq[3] = 8'h0F; exp_seq[4] = 8'h1E;

    rst_n = 0; enable = 0; seed_dv = 0; seed_data = '0; ready = 1;
    m_state = '0; m_ref = '0; m_data = '0; m_step = '0;
    m_valid = 0; m_done = 0; m_err = 0;

    // reset state
    tick(); tick();
    check("rst_data",  32'(data),     32'h0);
    check("rst_valid", 32'(valid),    32'h0);
    check("rst_step",  32'(step_cnt), 32'h0);

    // known-answer start of sequence
    rst_n = 1; enable = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("kat_seq",   32'(data),  32'(exp_seq[i]));
      check("kat_valid", 32'(valid), 32'h1);
    end

    // free-run to the period wrap (255 advances total)
    done_cnt = 0;
    for (int i = 0; i < 250; i++) begin
      prev_step = step_cnt;
      tick();
      if (done) begin
        done_cnt++;
        check("wrap_data", 32'(data),      32'h0);
        check("wrap_prev", 32'(prev_step), 32'd254);
      end
    end
    check("wrap_count", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("repeat_seq", 32'(data), 32'(exp_seq[i]));
    end

    // backpressure hold
    for (int i = 0; i < 7; i++) tick();
    held  = data;
    ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data",  32'(data),  32'(held));
      check("bp_hold_valid", 32'(valid), 32'h1);
    end
    ready = 1;
    for (int i = 0; i < 6; i++) tick();

    // seed 5A while streaming
    seed_dv = 1; seed_data = 8'h5A;
    tick();
    check("seed_valid", 32'(valid),    32'h0);
    check("seed_err0",  32'(seed_err), 32'h0);
    seed_dv = 0;
    tick();
    check("seed_first", 32'(data), 32'hB5);
    done_cnt = 0;
    for (int i = 0; i < 254; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("seed_wrap_cnt",  32'(done_cnt), 32'd1);
    check("seed_wrap_done", 32'(done),     32'h1);
    check("seed_wrap_data", 32'(data),     32'h5A);

    // lock-up seed
    seed_dv = 1; seed_data = 8'hFF;
    tick();
    check("ff_err",   32'(seed_err), 32'h1);
    check("ff_valid", 32'(valid),    32'h0);
    seed_dv = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ff_seq", 32'(data), 32'(exp_seq[i]));
    end

    // reset overrides a simultaneous lock-up seed
    rst_n = 0; seed_dv = 1; seed_data = 8'hFF;
    tick();
    check("rs_data",  32'(data),     32'h0);
    check("rs_valid", 32'(valid),    32'h0);
    check("rs_err",   32'(seed_err), 32'h0);
    check("rs_step",  32'(step_cnt), 32'h0);
    rst_n = 1; seed_dv = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rs_seq", 32'(data), 32'(exp_seq[i]));
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom % 8) != 0;
      ready     = ($urandom % 4) != 0;
      seed_dv   = ($urandom % 150) == 0;
      seed_data = (($urandom % 4) == 0) ? 8'hFF : 8'($urandom);
      rst_n     = ($urandom % 600) != 0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
